adder_axil_sequencer: RTL and testbench

//  AXI4-Lite master that runs one add on the memory-mapped adder slave per command.

---
 rtl/adder_axil_sequencer_if.sv | 42 ++++
 rtl/adder_axil_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_adder_axil_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_axil_sequencer_if.sv
// AXI4-Lite bus bundle between the adder sequencer (master) and the adder
// register slave. All five channels are carried here. The master modport
// drives the address/data/valid/ready signals that a master owns, and the
// slave modport mirrors it.
interface adder_axil_sequencer_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input  bresp, bvalid, output bready,
      output araddr, arvalid, input arready,
      input  rdata, rresp, rvalid, output rready
   );

   modport slave (
      input  awaddr, awvalid, output awready,
      input  wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input  araddr, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface

// File: rtl/adder_axil_sequencer.sv
// AXI4-Lite master that performs one add on the memory-mapped adder per
// command. It writes operand A, then operand B, reads the result register,
// and returns the sum (or an error code) on the result handshake.
//
// Ports
//   s0_axi_aclk      clock, rising edge
//   s0_axi_aresetn   asynchronous active-low reset
//   cmd_valid/ready  command handshake, operands cmd_a / cmd_b
//   res_valid/ready  result handshake, res_sum / res_err
//                    (res_err: 00 ok, 01 write resp, 10 read resp, 11 timeout)
//   m0_axi           AXI4-Lite master bus
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// WR_A  | write operand A: AW/W phase, then B phase (bready)
// WR_B  | write operand B: AW/W phase, then B phase (bready)
// RD    | read result: AR phase, then R phase (rready)
// RESP  | res_valid high, holding sum/err until res_ready
module adder_axil_sequencer #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] OPA_ADDR   = 'h00,
   parameter logic [ADDR_WIDTH-1:0] OPB_ADDR   = 'h04,
   parameter logic [ADDR_WIDTH-1:0] RES_ADDR   = 'h08,
   parameter int unsigned           TIMEOUT    = 255
) (
   input  logic                  s0_axi_aclk,
   input  logic                  s0_axi_aresetn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [DATA_WIDTH-1:0] cmd_a,
   input  logic [DATA_WIDTH-1:0] cmd_b,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [DATA_WIDTH-1:0] res_sum,
   output logic [1:0]            res_err,
   adder_axil_sequencer_if.master m0_axi
);

   localparam int unsigned      CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
   localparam int               STRB_W   = DATA_WIDTH / 8;

   localparam logic [1:0] ERR_OK = 2'b00;
   localparam logic [1:0] ERR_WR = 2'b01;
   localparam logic [1:0] ERR_RD = 2'b10;
   localparam logic [1:0] ERR_TO = 2'b11;

   typedef enum logic [2:0] {IDLE, WR_A, WR_B, RD, RESP} state_t;

   state_t                  state_q,     state_d;
   logic                    cmd_ready_q, cmd_ready_d;
   logic                    res_valid_q, res_valid_d;
   logic [DATA_WIDTH-1:0]   res_sum_q,   res_sum_d;
   logic [1:0]              res_err_q,   res_err_d;
   logic [DATA_WIDTH-1:0]   op_b_q,      op_b_d;
   logic [CNT_W-1:0]        cnt_q,       cnt_d;
   logic [ADDR_WIDTH-1:0]   awaddr_q,    awaddr_d;
   logic                    awvalid_q,   awvalid_d;
   logic [DATA_WIDTH-1:0]   wdata_q,     wdata_d;
   logic [STRB_W-1:0]       wstrb_q,     wstrb_d;
   logic                    wvalid_q,    wvalid_d;
   logic                    bready_q,    bready_d;
   logic [ADDR_WIDTH-1:0]   araddr_q,    araddr_d;
   logic                    arvalid_q,   arvalid_d;
   logic                    rready_q,    rready_d;
   logic                    busy;
   logic                    to_hit;

   always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
      if (!s0_axi_aresetn) begin
         state_q     <= IDLE;
         cmd_ready_q <= 1'b1;
         res_valid_q <= 1'b0;
         res_sum_q   <= '0;
         res_err_q   <= ERR_OK;
         op_b_q      <= '0;
         cnt_q       <= '0;
         awaddr_q    <= '0;
         awvalid_q   <= 1'b0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         araddr_q    <= '0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         res_valid_q <= res_valid_d;
         res_sum_q   <= res_sum_d;
         res_err_q   <= res_err_d;
         op_b_q      <= op_b_d;
         cnt_q       <= cnt_d;
         awaddr_q    <= awaddr_d;
         awvalid_q   <= awvalid_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         araddr_q    <= araddr_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cmd_ready_d = cmd_ready_q;
      res_valid_d = res_valid_q;
      res_sum_d   = res_sum_q;
      res_err_d   = res_err_q;
      op_b_d      = op_b_q;
      cnt_d       = cnt_q;
      awaddr_d    = awaddr_q;
      awvalid_d   = awvalid_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      araddr_d    = araddr_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;

      busy   = (state_q == WR_A) || (state_q == WR_B) || (state_q == RD);
      // The abort fires on the edge where the count would reach TIMEOUT.
      to_hit = (TIMEOUT != 0) && busy && (cnt_q == CNT_LAST);

      if (busy && (TIMEOUT != 0)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               op_b_d      = cmd_b;
               res_err_d   = ERR_OK;
               cnt_d       = '0;
               cmd_ready_d = 1'b0;
               awaddr_d    = OPA_ADDR;
               wdata_d     = cmd_a;
               wstrb_d     = '1;
               awvalid_d   = 1'b1;
               wvalid_d    = 1'b1;
               state_d     = WR_A;
            end
         end

         WR_A, WR_B: begin
            if (bready_q) begin
               if (m0_axi.bvalid) begin
                  bready_d = 1'b0;
                  if (m0_axi.bresp != 2'b00) begin
                     res_err_d   = ERR_WR;
                     res_sum_d   = '0;
                     res_valid_d = 1'b1;
                     state_d     = RESP;
                  end else if (state_q == WR_A) begin
                     awaddr_d  = OPB_ADDR;
                     wdata_d   = op_b_q;
                     awvalid_d = 1'b1;
                     wvalid_d  = 1'b1;
                     state_d   = WR_B;
                  end else begin
                     araddr_d  = RES_ADDR;
                     arvalid_d = 1'b1;
                     state_d   = RD;
                  end
               end
            end else begin
               // AW and W complete independently; B is only accepted once both have.
               if (awvalid_q && m0_axi.awready) awvalid_d = 1'b0;
               if (wvalid_q && m0_axi.wready)   wvalid_d  = 1'b0;
               if (!awvalid_d && !wvalid_d)     bready_d  = 1'b1;
            end
         end

         RD: begin
            if (arvalid_q) begin
               if (m0_axi.arready) begin
                  arvalid_d = 1'b0;
                  rready_d  = 1'b1;
               end
            end else if (rready_q && m0_axi.rvalid) begin
               rready_d    = 1'b0;
               res_valid_d = 1'b1;
               state_d     = RESP;
               if (m0_axi.rresp != 2'b00) begin
                  res_err_d = ERR_RD;
                  res_sum_d = '0;
               end else begin
                  res_sum_d = m0_axi.rdata;
               end
            end
         end

         RESP: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase

      // Timeout overrides any handshake in the same cycle; late B/R are then
      // ignored because bready/rready stay low until the next command.
      if (to_hit) begin
         awvalid_d   = 1'b0;
         wvalid_d    = 1'b0;
         bready_d    = 1'b0;
         arvalid_d   = 1'b0;
         rready_d    = 1'b0;
         res_err_d   = ERR_TO;
         res_sum_d   = '0;
         res_valid_d = 1'b1;
         state_d     = RESP;
      end
   end

   assign cmd_ready      = cmd_ready_q;
   assign res_valid      = res_valid_q;
   assign res_sum        = res_sum_q;
   assign res_err        = res_err_q;
   assign m0_axi.awaddr  = awaddr_q;
   assign m0_axi.awvalid = awvalid_q;
   assign m0_axi.wdata   = wdata_q;
   assign m0_axi.wstrb   = wstrb_q;
   assign m0_axi.wvalid  = wvalid_q;
   assign m0_axi.bready  = bready_q;
   assign m0_axi.araddr  = araddr_q;
   assign m0_axi.arvalid = arvalid_q;
   assign m0_axi.rready  = rready_q;

endmodule

// File: tb/tb_adder_axil_sequencer.sv
// Bench for adder_axil_sequencer: a behavioural AXI4-Lite adder slave with
// configurable wait states and responses, a table of directed vectors,
// hand-written corner sequences and a randomized loop against a plain
// arithmetic reference model.
module tb_adder_axil_sequencer;
   localparam int DW = 32;
   localparam int AW = 8;
   localparam int TO = 20;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [DW-1:0] cmd_a = '0;
   logic [DW-1:0] cmd_b = '0;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic [DW-1:0] res_sum;
   logic [1:0]    res_err;

   always #5 clk = ~clk;

   adder_axil_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) axi ();

   adder_axil_sequencer #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
      .OPA_ADDR(8'h00), .OPB_ADDR(8'h04), .RES_ADDR(8'h08),
      .TIMEOUT(TO)
   ) dut (
      .s0_axi_aclk(clk), .s0_axi_aresetn(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_sum(res_sum), .res_err(res_err),
      .m0_axi(axi)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural slave ----------------
   int         aw_d, w_d, b_d, ar_d, r_d;
   logic [1:0] bresp_a, bresp_b, rresp_cfg;
   bit         ar_never, timeout_expected;
   bit         aw_done, w_done, ar_done;
   int         aw_c, w_c, b_c, r_c, ar_c;
   logic [7:0] awaddr_l;
   logic [31:0] wdata_l, reg_a, reg_b;
   int         wr_n, ar_n, viol;
   logic [7:0] wr_addr [4];
   logic [31:0] wr_data [4];
   logic       p_awvalid, p_wvalid, p_bready, p_arvalid, p_rready;
   logic [7:0] p_awaddr, p_araddr;
   logic [31:0] p_wdata;

   task automatic slave_clear();
      axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
      axi.arready = 0; axi.rvalid = 0; axi.rresp = 0; axi.rdata = 0;
      aw_done = 0; w_done = 0; ar_done = 0;
      aw_c = 0; w_c = 0; b_c = 0; r_c = 0; ar_c = 0;
      p_awvalid = 0; p_wvalid = 0; p_bready = 0; p_arvalid = 0; p_rready = 0;
      p_awaddr = 0; p_araddr = 0; p_wdata = 0;
   endtask

   initial begin
      viol = 0; wr_n = 0; ar_n = 0; reg_a = 0; reg_b = 0;
      aw_d = 0; w_d = 0; b_d = 0; ar_d = 0; r_d = 0;
      bresp_a = 0; bresp_b = 0; rresp_cfg = 0; ar_never = 0; timeout_expected = 0;
      slave_clear();
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            slave_clear();
            continue;
         end
         // held-valid / stable-payload / single-outstanding monitor
         if (!timeout_expected) begin
            if (p_awvalid && !axi.awready && (!axi.awvalid || axi.awaddr !== p_awaddr)) viol++;
            if (p_wvalid && !axi.wready && (!axi.wvalid || axi.wdata !== p_wdata)) viol++;
            if (p_arvalid && !axi.arready && (!axi.arvalid || axi.araddr !== p_araddr)) viol++;
         end
         if ((axi.awvalid || axi.wvalid || axi.bready) && (axi.arvalid || axi.rready)) viol++;
         // retire handshakes completed on the preceding rising edge
         if (axi.awready && p_awvalid) begin aw_done = 1; awaddr_l = p_awaddr; axi.awready = 0; aw_c = 0; end
         if (axi.wready && p_wvalid) begin w_done = 1; wdata_l = p_wdata; axi.wready = 0; w_c = 0; end
         if (axi.bvalid && p_bready) begin
            if (wr_n < 4) begin wr_addr[wr_n] = awaddr_l; wr_data[wr_n] = wdata_l; end
            wr_n++;
            if (awaddr_l == 8'h00) reg_a = wdata_l;
            else if (awaddr_l == 8'h04) reg_b = wdata_l;
            axi.bvalid = 0; aw_done = 0; w_done = 0; b_c = 0;
         end
         if (axi.arready && p_arvalid) begin ar_done = 1; ar_n++; axi.arready = 0; ar_c = 0; end
         if (axi.rvalid && p_rready) begin axi.rvalid = 0; ar_done = 0; r_c = 0; end
         // issue new responses
         if (!aw_done && axi.awvalid && !axi.awready) begin
            if (aw_c >= aw_d) axi.awready = 1; else aw_c++;
         end
         if (!w_done && axi.wvalid && !axi.wready) begin
            if (w_c >= w_d) axi.wready = 1; else w_c++;
         end
         if (aw_done && w_done && !axi.bvalid) begin
            if (b_c >= b_d) begin
               axi.bvalid = 1;
               axi.bresp = (awaddr_l == 8'h00) ? bresp_a : bresp_b;
            end else b_c++;
         end
         if (!ar_done && axi.arvalid && !axi.arready && !ar_never) begin
            if (ar_c >= ar_d) axi.arready = 1; else ar_c++;
         end
         if (ar_done && !axi.rvalid) begin
            if (r_c >= r_d) begin
               axi.rvalid = 1;
               axi.rresp = rresp_cfg;
               axi.rdata = (rresp_cfg == 2'b00) ? reg_a + reg_b : 32'hDEAD_BEEF;
            end else r_c++;
         end
         p_awvalid = axi.awvalid; p_wvalid = axi.wvalid; p_bready = axi.bready;
         p_arvalid = axi.arvalid; p_rready = axi.rready;
         p_awaddr = axi.awaddr; p_araddr = axi.araddr; p_wdata = axi.wdata;
      end
   end

   // ---------------- command helpers ----------------
   task automatic step();
      @(negedge clk);
      cyc++;
   endtask

   task automatic start_cmd(input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      wr_n = 0; ar_n = 0;
      while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
      chk("cmd_ready_idle", cmd_ready, 1'b1);
      cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      cyc = 1;
   endtask

   task automatic wait_res();
      while (!res_valid && cyc < 200) step();
      chk("res_valid_seen", res_valid, 1'b1);
   endtask

   task automatic consume();
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   task automatic set_slave(input int awd, input int wd, input logic [1:0] bra,
                            input logic [1:0] brb, input logic [1:0] rr);
      aw_d = awd; w_d = wd; bresp_a = bra; bresp_b = brb; rresp_cfg = rr;
   endtask

   function automatic logic [127:0] reset_vec();
      return {cmd_ready, res_valid, res_sum, res_err, axi.awvalid, axi.wvalid, axi.bready,
              axi.arvalid, axi.rready, axi.awaddr, axi.wdata, axi.araddr, axi.wstrb};
   endfunction

   localparam logic [92:0] RST_EXP = {1'b1, 1'b0, 32'h0, 2'b00, 5'b0, 8'h0, 32'h0, 8'h0, 4'h0};

   typedef struct {
      logic [31:0] a, b;
      logic [1:0]  bra, brb, rr;
      int          awd, wd;
      logic [31:0] exp_sum;
      logic [1:0]  exp_err;
      int          exp_wr, exp_ar;
   } vec_t;

   vec_t vecs [6];

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, b, e_sum;
      logic [1:0]  bra, brb, rr, e_err;
      int          e_wr, e_ar, n;
      bit          ok;

      vecs[0] = '{32'd5,          32'd7,          2'b00, 2'b00, 2'b00, 0, 0, 32'd12,  2'b00, 2, 1};
      vecs[1] = '{32'hFFFF_FFFF,  32'd1,          2'b00, 2'b00, 2'b00, 3, 0, 32'd0,   2'b00, 2, 1};
      vecs[2] = '{32'h0000_1234,  32'd1,          2'b10, 2'b00, 2'b00, 0, 0, 32'd0,   2'b01, 1, 0};
      vecs[3] = '{32'd10,         32'd20,         2'b00, 2'b00, 2'b11, 0, 0, 32'd0,   2'b10, 2, 1};
      vecs[4] = '{32'h8000_0000,  32'h8000_0000,  2'b00, 2'b01, 2'b00, 0, 0, 32'd0,   2'b01, 2, 0};
      vecs[5] = '{32'd100,        32'd200,        2'b00, 2'b00, 2'b00, 0, 2, 32'd300, 2'b00, 2, 1};

      // reset values
      repeat (3) @(negedge clk);
      chk("reset_values", reset_vec(), RST_EXP);
      rst_n = 1'b1;
      @(negedge clk);

      // table-driven vectors
      for (int i = 0; i < 6; i++) begin
         set_slave(vecs[i].awd, vecs[i].wd, vecs[i].bra, vecs[i].brb, vecs[i].rr);
         start_cmd(vecs[i].a, vecs[i].b);
         wait_res();
         if (i == 0) chk("latency_zero_wait", cyc, 7);
         chk($sformatf("vec%0d_sum", i), res_sum, vecs[i].exp_sum);
         chk($sformatf("vec%0d_err", i), res_err, vecs[i].exp_err);
         consume();
         chk($sformatf("vec%0d_writes", i), wr_n, vecs[i].exp_wr);
         chk($sformatf("vec%0d_reads", i), ar_n, vecs[i].exp_ar);
         chk($sformatf("vec%0d_wr0", i), {wr_addr[0], wr_data[0]}, {8'h00, vecs[i].a});
         if (vecs[i].exp_wr == 2)
            chk($sformatf("vec%0d_wr1", i), {wr_addr[1], wr_data[1]}, {8'h04, vecs[i].b});
      end

      // wready three cycles ahead of awready: valids drop independently
      set_slave(3, 0, 2'b00, 2'b00, 2'b00);
      start_cmd(32'hFFFF_FFFF, 32'd1);
      chk("split_c1_aw_w", {axi.awvalid, axi.wvalid}, 2'b11);
      step();
      chk("split_c2_w_dropped", {axi.awvalid, axi.wvalid}, 2'b10);
      step(); step();
      chk("split_c4_aw_held", {axi.awvalid, axi.wvalid, axi.bready}, 3'b100);
      step();
      chk("split_c5_bready", {axi.awvalid, axi.wvalid, axi.bready}, 3'b001);
      wait_res();
      chk("split_sum_err", {res_sum, res_err}, {32'd0, 2'b00});
      consume();

      // AR never accepted: timeout after TO cycles
      set_slave(0, 0, 2'b00, 2'b00, 2'b00);
      ar_never = 1; timeout_expected = 1;
      start_cmd(32'd9, 32'd9);
      while (cyc < TO) step();
      chk("timeout_arvalid_before", {axi.arvalid, res_valid}, 2'b10);
      step();
      chk("timeout_arvalid_after", {axi.arvalid, axi.rready, axi.bready, res_valid}, 4'b0001);
      chk("timeout_result", {res_sum, res_err}, {32'd0, 2'b11});
      consume();
      ar_never = 0; timeout_expected = 0;
      @(negedge clk);

      // result stall with a pending command, then reset mid WR_B
      start_cmd(32'd11, 32'd22);
      wait_res();
      cmd_a = 32'h33; cmd_b = 32'h44; cmd_valid = 1'b1;
      ok = 1;
      for (int k = 0; k < 10; k++) begin
         if (!(res_valid && !cmd_ready && res_sum == 32'd33 && res_err == 2'b00)) ok = 0;
         @(negedge clk);
      end
      chk("stall_stable", ok, 1'b1);
      consume();
      chk("after_consume_idle", {cmd_ready, res_valid}, 2'b10);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("pending_accepted", {cmd_ready, axi.awvalid, axi.awaddr}, {1'b0, 1'b1, 8'h00});
      n = 0;
      while (!(axi.awvalid && axi.awaddr == 8'h04) && n < 30) begin @(negedge clk); n++; end
      chk("reached_wr_b", {axi.awvalid, axi.awaddr, axi.wdata}, {1'b1, 8'h04, 32'h44});
      #2 rst_n = 1'b0;
      #1 chk("reset_mid_wr_b", reset_vec(), RST_EXP);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start_cmd(32'd3, 32'd4);
      wait_res();
      chk("after_reset_sum", {res_sum, res_err}, {32'd7, 2'b00});
      consume();

      // randomized commands against the arithmetic model
      for (int it = 0; it < 40; it++) begin
         a = $urandom; b = $urandom;
         bra = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         brb = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         rr  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         set_slave($urandom_range(0, 1), $urandom_range(0, 1), bra, brb, rr);
         b_d = $urandom_range(0, 1); ar_d = $urandom_range(0, 1); r_d = $urandom_range(0, 1);
         if (bra != 0)      begin e_sum = 0;     e_err = 2'b01; e_wr = 1; e_ar = 0; end
         else if (brb != 0) begin e_sum = 0;     e_err = 2'b01; e_wr = 2; e_ar = 0; end
         else if (rr != 0)  begin e_sum = 0;     e_err = 2'b10; e_wr = 2; e_ar = 1; end
         else               begin e_sum = a + b; e_err = 2'b00; e_wr = 2; e_ar = 1; end
         start_cmd(a, b);
         wait_res();
         chk($sformatf("rand%0d_result", it), {res_sum, res_err}, {e_sum, e_err});
         consume();
         chk($sformatf("rand%0d_txns", it), {wr_n, ar_n}, {e_wr, e_ar});
      end
      b_d = 0; ar_d = 0; r_d = 0;

      chk("protocol_violations", viol, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
